// File: rtl/prog_sequencer_if.sv
// Bus between the program sequencer, its instruction ROM and the
// control unit: run/step/clear controls, fetched instruction and
// result bit in, program counter and execute status out.
interface prog_sequencer_if #(
  parameter int N = 4
) ();

  // Controls and datapath inputs to the sequencer
  logic         run;
  logic         step;
  logic         clear;
  logic [7:0]   instruction;
  logic         result;

  // Sequencer outputs
  logic [N-1:0] addr;
  logic [7:0]   instr_q;
  logic         exec_en;
  logic         busy;
  logic         halted;
  logic         wrap;

  // The sequencer itself
  modport master (
    input  run, step, clear, instruction, result,
    output addr, instr_q, exec_en, busy, halted, wrap
  );

  // ROM / control unit / operator side
  modport slave (
    output run, step, clear, instruction, result,
    input  addr, instr_q, exec_en, busy, halted, wrap
  );

endinterface

// File: rtl/prog_sequencer.sv
// Fetch/execute program sequencer.
// Drives the ROM address, latches the fetched instruction, and issues a
// one-cycle execute strobe for ordinary opcodes. JMP (E), SKIPZ (D) and
// HALT (F) are resolved here and never reach the control unit.
// Supports continuous run, single-step, and halt with clear.
// N must lie in 1..4 because jump targets come from instruction[3:0].
module prog_sequencer #(
  parameter int N = 4
) (
  input  logic               clk,
  input  logic               rst,     // asynchronous, active low
  prog_sequencer_if.master   bus
);

  localparam logic [3:0] OP_SKIPZ = 4'hD;
  localparam logic [3:0] OP_JMP   = 4'hE;
  localparam logic [3:0] OP_HALT  = 4'hF;

  typedef enum logic [1:0] {
    S_IDLE,
    S_FETCH,
    S_EXEC,
    S_HALTED
  } state_t;

  state_t       state_q,     state_d;
  logic [N-1:0] addr_q,      addr_d;
  logic [7:0]   instr_q,     instr_d;
  logic         step_mode_q, step_mode_d;
  logic         exec_en_q,   exec_en_d;
  logic         busy_q,      busy_d;
  logic         halted_q,    halted_d;
  logic         wrap_q,      wrap_d;

  // Sums are one bit wider than the PC so the top bit flags a rollover.
  logic [N:0]   addr_inc1;
  logic [N:0]   addr_inc2;
  logic [N:0]   addr_next_seq;
  logic [3:0]   exec_op;
  logic [3:0]   fetch_op;

  // True for the opcodes the sequencer consumes itself.
  function automatic logic is_control(input logic [3:0] op);
    return (op == OP_JMP) || (op == OP_SKIPZ) || (op == OP_HALT);
  endfunction

  assign exec_op   = instr_q[7:4];
  assign fetch_op  = bus.instruction[7:4];
  assign addr_inc1 = {1'b0, addr_q} + (N+1)'(1);
  assign addr_inc2 = {1'b0, addr_q} + (N+1)'(2);

  // Sequential successor: SKIPZ with a zero result skips one word.
  always_comb begin
    addr_next_seq = addr_inc1;
    if ((exec_op == OP_SKIPZ) && !bus.result) begin
      addr_next_seq = addr_inc2;
    end
  end

  // Next-state and next-output logic for the fetch/execute controller.
  always_comb begin
    // NOTE: every signal gets a default before the case so that no path
    // leaves one unassigned, which would otherwise infer a latch.
    state_d     = state_q;
    addr_d      = addr_q;
    instr_d     = instr_q;
    step_mode_d = step_mode_q;
    exec_en_d   = 1'b0;
    wrap_d      = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        // run has priority; a lone step pulse executes one instruction.
        if (bus.run) begin
          step_mode_d = 1'b0;
          state_d     = S_FETCH;
        end else if (bus.step) begin
          step_mode_d = 1'b1;
          state_d     = S_FETCH;
        end
      end

      S_FETCH: begin
        // The strobe is decided from the incoming word so that it is a
        // flop output in EXEC rather than a decode of instr_q.
        instr_d   = bus.instruction;
        exec_en_d = !is_control(fetch_op);
        state_d   = S_EXEC;
      end

      S_EXEC: begin
        if (exec_op == OP_HALT) begin
          // PC stays on the HALT word so the stop point is visible.
          state_d = S_HALTED;
        end else begin
          if (exec_op == OP_JMP) begin
            addr_d = instr_q[N-1:0];
          end else begin
            addr_d = addr_next_seq[N-1:0];
            wrap_d = addr_next_seq[N];
          end
          state_d = (bus.run && !step_mode_q) ? S_FETCH : S_IDLE;
        end
      end

      S_HALTED: begin
        // Only clear leaves HALTED; run and step are deliberately ignored.
        if (bus.clear) begin
          addr_d  = '0;
          state_d = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Status flags are registered copies of the state being entered.
    busy_d   = (state_d == S_FETCH) || (state_d == S_EXEC);
    halted_d = (state_d == S_HALTED);
  end

  // State and output registers; reset aborts any instruction in flight.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      addr_q      <= '0;
      instr_q     <= 8'h00;
      step_mode_q <= 1'b0;
      exec_en_q   <= 1'b0;
      busy_q      <= 1'b0;
      halted_q    <= 1'b0;
      wrap_q      <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments here so every register samples the
      // pre-edge values, regardless of statement order.
      state_q     <= state_d;
      addr_q      <= addr_d;
      instr_q     <= instr_d;
      step_mode_q <= step_mode_d;
      exec_en_q   <= exec_en_d;
      busy_q      <= busy_d;
      halted_q    <= halted_d;
      wrap_q      <= wrap_d;
    end
  end

  assign bus.addr    = addr_q;
  assign bus.instr_q = instr_q;
  assign bus.exec_en = exec_en_q;
  assign bus.busy    = busy_q;
  assign bus.halted  = halted_q;
  assign bus.wrap    = wrap_q;

endmodule

// File: tb/tb_prog_sequencer.sv
// Directed testbench for prog_sequencer (N=4) with a combinational ROM.
module tb_prog_sequencer;

  localparam int N = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic [7:0] rom [16];

  int checks   = 0;
  int failures = 0;

  prog_sequencer_if #(.N(N)) sif ();

  prog_sequencer #(.N(N)) dut (
    .clk (clk),
    .rst (rst),
    .bus (sif)
  );

  assign sif.instruction = rom[sif.addr];

  always #5 clk = ~clk;

  // Advance one clock and settle just after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Fill the ROM with ordinary opcodes 1..C (high nibble), low nibble 0.
  task automatic load_normal();
    for (int i = 0; i < 16; i++) begin
      rom[i] = {4'((i % 12) + 1), 4'h0};
    end
  endtask

  task automatic do_reset();
    sif.run = 1'b0; sif.step = 1'b0; sif.clear = 1'b0; sif.result = 1'b0;
    rst = 1'b0;
    tick();
    tick();
    rst = 1'b1;
  endtask

  task automatic test_reset();
    load_normal();
    sif.run = 1'b0; sif.step = 1'b0; sif.clear = 1'b0; sif.result = 1'b0;
    rst = 1'b0;
    tick();
    checks++; if (sif.addr !== 4'd0) begin failures++; $display("FAIL reset_addr: got %0d expected 0", sif.addr); end
    checks++; if (sif.instr_q !== 8'h00) begin failures++; $display("FAIL reset_instr: got %0h expected 00", sif.instr_q); end
    checks++; if ({sif.exec_en, sif.busy, sif.halted, sif.wrap} !== 4'b0000) begin
      failures++; $display("FAIL reset_flags: got %b expected 0000", {sif.exec_en, sif.busy, sif.halted, sif.wrap}); end
    rst = 1'b1;
    tick();
    tick();
    checks++; if (sif.busy !== 1'b0) begin failures++; $display("FAIL reset_idle: busy got %b expected 0", sif.busy); end

    // Reset asserted mid-EXEC of the instruction at addr 2.
    sif.run = 1'b1;
    repeat (6) tick();
    checks++; if (sif.exec_en !== 1'b1 || sif.addr !== 4'd2) begin
      failures++; $display("FAIL reset_pre_exec: exec_en=%b addr=%0d expected 1/2", sif.exec_en, sif.addr); end
    #2 rst = 1'b0;
    #1;
    checks++; if (sif.addr !== 4'd0) begin failures++; $display("FAIL reset_async_addr: got %0d expected 0", sif.addr); end
    checks++; if ({sif.exec_en, sif.busy, sif.halted} !== 3'b000) begin
      failures++; $display("FAIL reset_async_flags: got %b expected 000", {sif.exec_en, sif.busy, sif.halted}); end
    sif.run = 1'b0;
    #1 rst = 1'b1;
    tick();
    tick();
    checks++; if (sif.busy !== 1'b0 || sif.addr !== 4'd0) begin
      failures++; $display("FAIL reset_after_release: busy=%b addr=%0d expected 0/0", sif.busy, sif.addr); end
    sif.step = 1'b1;
    tick();
    sif.step = 1'b0;
    checks++; if (sif.busy !== 1'b1) begin failures++; $display("FAIL reset_idle_step: busy got %b expected 1", sif.busy); end
    tick();
    tick();
  endtask

  task automatic test_sequential();
    do_reset();
    load_normal();
    sif.run = 1'b1;
    for (int i = 0; i < 16; i++) begin
      tick();
      checks++; if (sif.addr !== 4'(i) || sif.busy !== 1'b1 || sif.exec_en !== 1'b0 || sif.wrap !== 1'b0) begin
        failures++; $display("FAIL seq_fetch%0d: addr=%0d busy=%b exec_en=%b wrap=%b expected %0d/1/0/0",
                             i, sif.addr, sif.busy, sif.exec_en, sif.wrap, i); end
      tick();
      checks++; if (sif.exec_en !== 1'b1 || sif.instr_q !== rom[i] || sif.wrap !== 1'b0) begin
        failures++; $display("FAIL seq_exec%0d: exec_en=%b instr_q=%0h wrap=%b expected 1/%0h/0",
                             i, sif.exec_en, sif.instr_q, sif.wrap, rom[i]); end
    end
    tick();
    checks++; if (sif.addr !== 4'd0 || sif.wrap !== 1'b1) begin
      failures++; $display("FAIL seq_wrap: addr=%0d wrap=%b expected 0/1", sif.addr, sif.wrap); end
    // run dropped in FETCH: current instruction still completes.
    sif.run = 1'b0;
    tick();
    checks++; if (sif.wrap !== 1'b0 || sif.exec_en !== 1'b1) begin
      failures++; $display("FAIL seq_wrap_once: wrap=%b exec_en=%b expected 0/1", sif.wrap, sif.exec_en); end
    tick();
    checks++; if (sif.busy !== 1'b0 || sif.addr !== 4'd1 || sif.exec_en !== 1'b0) begin
      failures++; $display("FAIL seq_stop: busy=%b addr=%0d exec_en=%b expected 0/1/0", sif.busy, sif.addr, sif.exec_en); end
  endtask

  task automatic test_jmp();
    do_reset();
    load_normal();
    rom[3] = 8'hE9;
    sif.run = 1'b1;
    repeat (8) tick();  // F0 E0 F1 E1 F2 E2 F3 E3
    checks++; if (sif.exec_en !== 1'b0 || sif.instr_q !== 8'hE9 || sif.addr !== 4'd3) begin
      failures++; $display("FAIL jmp_exec: exec_en=%b instr_q=%0h addr=%0d expected 0/e9/3", sif.exec_en, sif.instr_q, sif.addr); end
    tick();
    checks++; if (sif.addr !== 4'd9 || sif.wrap !== 1'b0 || sif.busy !== 1'b1) begin
      failures++; $display("FAIL jmp_target: addr=%0d wrap=%b busy=%b expected 9/0/1", sif.addr, sif.wrap, sif.busy); end
    sif.run = 1'b0;
    tick();
    checks++; if (sif.exec_en !== 1'b1) begin failures++; $display("FAIL jmp_next_exec: got %b expected 1", sif.exec_en); end
    tick();
  endtask

  task automatic test_skipz();
    // result=0 at addr 5 -> 7
    do_reset();
    load_normal();
    rom[0] = 8'hE5; rom[5] = 8'hD0;
    sif.result = 1'b0; sif.run = 1'b1;
    repeat (4) tick();  // F0 E0 F5 E5
    checks++; if (sif.exec_en !== 1'b0 || sif.addr !== 4'd5) begin
      failures++; $display("FAIL skipz_exec: exec_en=%b addr=%0d expected 0/5", sif.exec_en, sif.addr); end
    tick();
    checks++; if (sif.addr !== 4'd7 || sif.wrap !== 1'b0) begin
      failures++; $display("FAIL skipz_r0: addr=%0d wrap=%b expected 7/0", sif.addr, sif.wrap); end
    sif.run = 1'b0;
    tick(); tick();

    // result=1 at addr 5 -> 6
    do_reset();
    load_normal();
    rom[0] = 8'hE5; rom[5] = 8'hD0;
    sif.result = 1'b1; sif.run = 1'b1;
    repeat (5) tick();
    checks++; if (sif.addr !== 4'd6 || sif.wrap !== 1'b0) begin
      failures++; $display("FAIL skipz_r1: addr=%0d wrap=%b expected 6/0", sif.addr, sif.wrap); end
    sif.run = 1'b0;
    tick(); tick();

    // result=0 at addr 15 -> 1 with wrap
    do_reset();
    load_normal();
    rom[0] = 8'hEF; rom[15] = 8'hD0;
    sif.result = 1'b0; sif.run = 1'b1;
    repeat (5) tick();
    checks++; if (sif.addr !== 4'd1 || sif.wrap !== 1'b1) begin
      failures++; $display("FAIL skipz_wrap: addr=%0d wrap=%b expected 1/1", sif.addr, sif.wrap); end
    sif.run = 1'b0;
    tick();
    checks++; if (sif.wrap !== 1'b0) begin failures++; $display("FAIL skipz_wrap_pulse: wrap got %b expected 0", sif.wrap); end
    tick();
  endtask

  task automatic test_step();
    int pulses;
    int busy_seen;
    do_reset();
    load_normal();
    pulses = 0;
    busy_seen = 0;
    sif.step = 1'b1;
    tick();
    sif.step = 1'b0;
    checks++; if (sif.busy !== 1'b1 || sif.exec_en !== 1'b0) begin
      failures++; $display("FAIL step_fetch: busy=%b exec_en=%b expected 1/0", sif.busy, sif.exec_en); end
    sif.step = 1'b1;  // ignored while busy
    tick();
    sif.step = 1'b0;
    if (sif.exec_en === 1'b1) pulses++;
    tick();
    checks++; if (sif.busy !== 1'b0 || sif.addr !== 4'd1) begin
      failures++; $display("FAIL step_done: busy=%b addr=%0d expected 0/1", sif.busy, sif.addr); end
    for (int i = 0; i < 4; i++) begin
      tick();
      if (sif.exec_en === 1'b1) pulses++;
      if (sif.busy === 1'b1) busy_seen++;
    end
    checks++; if (pulses != 1 || busy_seen != 0) begin
      failures++; $display("FAIL step_single: exec pulses=%0d busy cycles=%0d expected 1/0", pulses, busy_seen); end

    // clear outside HALTED does nothing
    sif.clear = 1'b1;
    tick();
    sif.clear = 1'b0;
    checks++; if (sif.addr !== 4'd1 || sif.halted !== 1'b0 || sif.busy !== 1'b0) begin
      failures++; $display("FAIL step_clear_idle: addr=%0d halted=%b busy=%b expected 1/0/0", sif.addr, sif.halted, sif.busy); end

    // run and step together -> continuous run
    sif.run = 1'b1; sif.step = 1'b1;
    tick();
    sif.step = 1'b0;
    tick();
    checks++; if (sif.exec_en !== 1'b1) begin failures++; $display("FAIL step_run_exec: got %b expected 1", sif.exec_en); end
    tick();
    checks++; if (sif.busy !== 1'b1 || sif.addr !== 4'd2) begin
      failures++; $display("FAIL step_run_cont: busy=%b addr=%0d expected 1/2", sif.busy, sif.addr); end
    sif.run = 1'b0;
    tick(); tick();
    checks++; if (sif.busy !== 1'b0 || sif.addr !== 4'd3) begin
      failures++; $display("FAIL step_run_stop: busy=%b addr=%0d expected 0/3", sif.busy, sif.addr); end
  endtask

  task automatic test_halt();
    do_reset();
    load_normal();
    rom[4] = 8'hF0;
    sif.run = 1'b1;
    repeat (10) tick();  // ... F4 E4
    checks++; if (sif.exec_en !== 1'b0 || sif.instr_q !== 8'hF0) begin
      failures++; $display("FAIL halt_exec: exec_en=%b instr_q=%0h expected 0/f0", sif.exec_en, sif.instr_q); end
    tick();
    checks++; if (sif.halted !== 1'b1 || sif.busy !== 1'b0 || sif.addr !== 4'd4) begin
      failures++; $display("FAIL halt_enter: halted=%b busy=%b addr=%0d expected 1/0/4", sif.halted, sif.busy, sif.addr); end
    sif.step = 1'b1;
    repeat (3) tick();
    sif.step = 1'b0;
    checks++; if (sif.halted !== 1'b1 || sif.busy !== 1'b0 || sif.addr !== 4'd4) begin
      failures++; $display("FAIL halt_hold: halted=%b busy=%b addr=%0d expected 1/0/4", sif.halted, sif.busy, sif.addr); end
    sif.run = 1'b0; sif.clear = 1'b1;
    tick();
    sif.clear = 1'b0;
    checks++; if (sif.halted !== 1'b0 || sif.addr !== 4'd0 || sif.busy !== 1'b0 || sif.wrap !== 1'b0) begin
      failures++; $display("FAIL halt_clear: halted=%b addr=%0d busy=%b wrap=%b expected 0/0/0/0",
                           sif.halted, sif.addr, sif.busy, sif.wrap); end
    tick();
    checks++; if (sif.busy !== 1'b0 || sif.halted !== 1'b0) begin
      failures++; $display("FAIL halt_idle: busy=%b halted=%b expected 0/0", sif.busy, sif.halted); end
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_jmp();
    test_skipz();
    test_step();
    test_halt();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
